// File: rtl/msg_pkg.sv
// msg_pkg: shared FSM state type and message/UART framing constants for msg_uart_reader
package msg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } msg_state_t;

  localparam logic [7:0] MSG_TERM  = 8'h00;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;
  localparam int         DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser with baud counter, bit counter and shift register
module uart_tx_byte
  import msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_go,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);
  localparam logic [3:0] STOP_IDX  = 4'(DATA_BITS + 1);

  logic                 r_active;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 w_bit_end;

  assign w_bit_end    = r_active && (r_baud == BAUD_LAST);
  assign o_frame_done = w_bit_end && (r_bit == STOP_IDX);
  assign o_tx         = r_tx;

  // bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit; tx moves only at bit ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= STOP_BIT;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= i_data;
      r_tx     <= START_BIT;
    end else if (w_bit_end) begin
      r_baud <= '0;
      r_bit  <= r_bit + 1'b1;
      if (r_bit == STOP_IDX) begin
        r_active <= 1'b0;
      end else if (r_bit == DATA_LAST) begin
        r_tx <= STOP_BIT;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= r_shift >> 1;
      end
    end else if (r_active) begin
      r_baud <= r_baud + 1'b1;
    end
  end

endmodule

// File: rtl/msg_uart_reader.sv
// msg_uart_reader: walks NUL-terminated text in data RAM and transmits it as 8N1 UART frames
module msg_uart_reader
  import msg_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_LEN      = 256,
  localparam int CW          = $clog2(MAX_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_ram_re,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [31:0]       i_ram_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done,
  output logic [CW-1:0]     o_count
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  msg_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ram_re;
  logic              r_busy;
  logic              r_done;
  logic              w_term;
  logic              w_go;
  logic              w_frame_done;
  logic              w_last;
  logic              w_unused;

  assign w_term     = i_ram_data[7:0] == MSG_TERM;
  assign w_go       = (r_state == S_LOAD) && !w_term;
  assign w_last     = (r_count + 1'b1) == MAX_CNT;
  assign w_unused   = ^i_ram_data[31:8];
  assign o_ram_re   = r_ram_re;
  assign o_ram_addr = r_ptr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;

  // the RAM word read in LOAD goes straight into the serialiser's shift register
  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_go        (w_go),
    .i_data      (i_ram_data[7:0]),
    .o_tx        (o_tx),
    .o_frame_done(w_frame_done)
  );

  // message FSM; ram_re/busy/done are registered alongside the state they belong to
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      r_ram_re <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ram_re <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ptr    <= i_base_addr;
            r_count  <= '0;
            r_ram_re <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_state <= w_term ? S_DONE : S_SEND;
          r_done  <= w_term;
        end
        S_SEND: begin
          if (w_frame_done) begin
            r_count  <= r_count + 1'b1;
            r_ptr    <= r_ptr + 1'b1;
            r_state  <= w_last ? S_DONE : S_FETCH;
            r_done   <= w_last;
            r_ram_re <= !w_last;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_uart_reader.sv
// tb_msg_uart_reader: scoreboard bench checking RAM reads, UART frames and done timing
module tb_msg_uart_reader;

  localparam int C  = 4;
  localparam int AW = 10;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data = '0;
  logic          tx;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  logic [31:0]   mem [0:1023];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int frames = 0;
  int reads = 0;

  logic [AW-1:0] exp_addr [$];
  logic [7:0]    exp_byte [$];
  logic [AW-1:0] ea;

  bit       in_frame = 1'b0;
  int       fcyc = 0;
  int       ferr = 0;
  logic [9:0] fbits = '0;
  logic [7:0] got = '0;

  always #5 clk = ~clk;

  msg_uart_reader #(
    .ADDR_W(AW),
    .CLKS_PER_BIT(C),
    .MAX_LEN(ML)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_base_addr(base_addr),
    .o_ram_re   (ram_re),
    .o_ram_addr (ram_addr),
    .i_ram_data (ram_data),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_done     (done),
    .o_count    (count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_re) ram_data <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc - t0 + 1;
    end
    if (ram_re === 1'b1) begin
      reads++;
      checks++;
      if (exp_addr.size() == 0) begin
        failures++;
        $display("FAIL ram_read unexpected addr=%h expected none", ram_addr);
      end else begin
        ea = exp_addr.pop_front();
        if (ram_addr !== ea) begin
          failures++;
          $display("FAIL ram_read addr=%h expected=%h", ram_addr, ea);
        end
      end
    end
    if (rst_n !== 1'b1) begin
      in_frame = 1'b0;
    end else if (in_frame) begin
      if (tx !== fbits[fcyc / C]) ferr++;
      if ((fcyc % C) == C / 2 && fcyc / C >= 1 && fcyc / C <= 8) got[fcyc / C - 1] = tx;
      fcyc++;
      if (fcyc == 10 * C) begin
        in_frame = 1'b0;
        frames++;
        checks++;
        if (ferr != 0) begin
          failures++;
          $display("FAIL frame got=%h expected=%h bad_cycles=%0d", got, fbits[8:1], ferr);
        end
      end
    end else if (tx === 1'b0) begin
      if (exp_byte.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_low unexpected frame start tx=%b expected=1", tx);
      end else begin
        fbits = {1'b1, exp_byte.pop_front(), 1'b0};
        in_frame = 1'b1;
        fcyc = 1;
        ferr = 0;
        got = '0;
      end
    end else if (tx !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tx_idle tx=%b expected=1", tx);
    end
  end

  function automatic logic [31:0] w(input logic [7:0] ch);
    return {24'hA5C3E7, ch};
  endfunction

  task automatic do_start(input logic [AW-1:0] a);
    @(negedge clk);
    start = 1'b1;
    base_addr = a;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int i = 0;
    while (done_cnt == d0 && i < 400) begin
      @(negedge clk);
      #1;
      i++;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL done_timeout done_cnt=%0d expected>%0d", done_cnt, d0);
    end
  endtask

  task automatic test_power_on();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tx, busy, done, ram_re, count} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL power_on tx/busy/done/re/count=%b%b%b%b/%0d expected=1000/0", tx, busy, done, ram_re, count);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_two_char();
    int d0, f0;
    mem[10'h10] = w(8'h48);
    mem[10'h11] = w(8'h69);
    mem[10'h12] = 32'hFFFF_FF00;
    exp_addr.push_back(10'h10);
    exp_addr.push_back(10'h11);
    exp_addr.push_back(10'h12);
    exp_byte.push_back(8'h48);
    exp_byte.push_back(8'h69);
    d0 = done_cnt;
    f0 = frames;
    do_start(10'h10);
    #1;
    checks++;
    if (busy !== 1'b1 || ram_re !== 1'b1) begin
      failures++;
      $display("FAIL two_char_cycle1 busy=%b ram_re=%b expected=1 1", busy, ram_re);
    end
    wait_done(d0);
    checks++;
    if (done_cyc !== 87) begin
      failures++;
      $display("FAIL two_char_latency cycle=%0d expected=87", done_cyc);
    end
    checks++;
    if (count !== CW'(2) || busy !== 1'b1) begin
      failures++;
      $display("FAIL two_char_at_done count=%0d busy=%b expected=2 1", count, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL two_char_after_done busy=%b done=%b expected=0 0", busy, done);
    end
    checks++;
    if (frames - f0 != 2 || done_cnt - d0 != 1 || exp_addr.size() != 0 || exp_byte.size() != 0) begin
      failures++;
      $display("FAIL two_char_totals frames=%0d dones=%0d left=%0d/%0d expected=2 1 0/0",
               frames - f0, done_cnt - d0, exp_addr.size(), exp_byte.size());
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (count !== CW'(2)) begin
      failures++;
      $display("FAIL count_hold count=%0d expected=2", count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, done, ram_re} !== 4'b1000 || count !== CW'(0)) begin
      failures++;
      $display("FAIL idle_reset tx/busy/done/re/count=%b%b%b%b/%0d expected=1000/0", tx, busy, done, ram_re, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty();
    int d0, f0;
    mem[10'h20] = 32'hFFFF_FF00;
    exp_addr.push_back(10'h20);
    d0 = done_cnt;
    f0 = frames;
    do_start(10'h20);
    wait_done(d0);
    checks++;
    if (done_cyc !== 3 || count !== CW'(0)) begin
      failures++;
      $display("FAIL empty done_cycle=%0d count=%0d expected=3 0", done_cyc, count);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (frames != f0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL empty_frames frames=%0d reads_left=%0d expected=0 0", frames - f0, exp_addr.size());
    end
  endtask

  task automatic test_len_limit();
    int d0, r0;
    for (int i = 0; i < 8; i++) mem[i] = w(8'h41);
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(AW'(i));
      exp_byte.push_back(8'h41);
    end
    d0 = done_cnt;
    r0 = reads;
    do_start(10'h000);
    wait_done(d0);
    checks++;
    if (done_cyc !== 169 || count !== CW'(4)) begin
      failures++;
      $display("FAIL len_limit done_cycle=%0d count=%0d expected=169 4", done_cyc, count);
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (reads - r0 != 4 || exp_byte.size() != 0) begin
      failures++;
      $display("FAIL len_limit_reads reads=%0d frames_left=%0d expected=4 0", reads - r0, exp_byte.size());
    end
  endtask

  task automatic test_start_while_busy();
    int d0;
    mem[10'h30] = w(8'h55);
    exp_addr.push_back(10'h10);
    exp_addr.push_back(10'h11);
    exp_addr.push_back(10'h12);
    exp_byte.push_back(8'h48);
    exp_byte.push_back(8'h69);
    d0 = done_cnt;
    do_start(10'h10);
    repeat (8) @(negedge clk);
    start = 1'b1;
    base_addr = 10'h30;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    checks++;
    if (done_cyc !== 87 || count !== CW'(2) || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL start_while_busy done_cycle=%0d count=%0d reads_left=%0d expected=87 2 0",
               done_cyc, count, exp_addr.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    mem[10'h40] = w(8'h41);
    mem[10'h41] = w(8'h42);
    mem[10'h50] = w(8'h5A);
    mem[10'h51] = 32'hFFFF_FF00;
    exp_addr.push_back(10'h40);
    exp_byte.push_back(8'h41);
    do_start(10'h40);
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ram_re !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame tx=%b busy=%b ram_re=%b expected=1 0 0", tx, busy, ram_re);
    end
    exp_addr.delete();
    exp_byte.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_addr.push_back(10'h50);
    exp_addr.push_back(10'h51);
    exp_byte.push_back(8'h5A);
    d0 = done_cnt;
    f0 = frames;
    do_start(10'h50);
    wait_done(d0);
    checks++;
    if (count !== CW'(1) || frames - f0 != 1 || done_cyc !== 45) begin
      failures++;
      $display("FAIL restart count=%0d frames=%0d done_cycle=%0d expected=1 1 45", count, frames - f0, done_cyc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int d0;
    mem[10'h3FF] = w(8'h41);
    mem[10'h000] = 32'hFFFF_FF00;
    exp_addr.push_back(10'h3FF);
    exp_addr.push_back(10'h000);
    exp_byte.push_back(8'h41);
    d0 = done_cnt;
    do_start(10'h3FF);
    wait_done(d0);
    checks++;
    if (count !== CW'(1) || done_cyc !== 45 || exp_addr.size() != 0 || exp_byte.size() != 0) begin
      failures++;
      $display("FAIL wrap count=%0d done_cycle=%0d left=%0d/%0d expected=1 45 0/0",
               count, done_cyc, exp_addr.size(), exp_byte.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FF00;
    test_power_on();
    test_two_char();
    test_reset();
    test_empty();
    test_len_limit();
    test_start_while_busy();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_uart_reader.md
# msg_uart_reader

Memory-side reader that pulls a decoded message out of data RAM and serialises it on a UART TX line. It is the consumer for the text the CPU writes into data RAM: the processor writes one character per word, and this block walks those words from a base address and transmits each character as an 8N1 frame. It stops at the first 0x00 terminator or after MAX_LEN characters. It sits beside the RAM on a dedicated synchronous read port and never drives the CPU bus.

## Interface
- ADDR_W, 10, RAM word-address width
- CLKS_PER_BIT, 434, clk cycles per UART bit; must be ≥ 2
- MAX_LEN, 256, maximum characters sent per message
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request to send; sampled only in IDLE
- base_addr  in  ADDR_W  word address of first character; captured with start
- ram_re  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM word address
- ram_data  in  32  read data, valid the cycle after ram_re; character in [7:0], [31:8] ignored
- tx  out  1  UART line, idle high
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse at end of message
- count  out  $clog2(MAX_LEN+1)  characters sent in the current or last message

## Operation
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE + start=1: capture base_addr into ptr, clear count, go to FETCH. In any other state start is ignored.
- FETCH: ram_re=1, ram_addr=ptr, go to LOAD.
- LOAD: latch ram_data[7:0].
  - If the byte is 0x00, go to DONE.
  - Otherwise launch a frame, go to SEND.
- SEND: wait for frame complete, then count+1 and ptr+1 (mod 2^ADDR_W, so it wraps at the top of RAM).
  - Next state is DONE if count now equals MAX_LEN, else FETCH.
- DONE: done=1 for one cycle, then return to IDLE.
- Frame format: start bit 0, data[0]..data[7] LSB first, stop bit 1. Each bit is held CLKS_PER_BIT cycles.
- ram_re is 0 outside FETCH. ram_addr holds ptr at all times.
- Reset (asynchronous, any state, mid-frame included):
  - tx=1, busy=0, done=0, ram_re=0, count=0, ptr=0, state IDLE.
  - No partial frame resumes after reset.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycle 1: FETCH, ram_re=1.
- Cycle 2: LOAD, data latched.
- Cycle 3: tx=0, the first start-bit cycle.
- Each character costs 10·CLKS_PER_BIT + 2 cycles, FETCH and LOAD included.
- The stop bit's last cycle is followed by FETCH of the next address.
- Terminator read in LOAD leads to DONE on the next cycle. An empty message therefore pulses done in cycle 3 and never drives tx low.
- busy rises in cycle 1 and falls in the cycle after DONE.
- tx changes only at bit boundaries, driven from a register with no glitches.

## Structure
- Package msg_pkg holds:
  - the state enum type (IDLE, FETCH, LOAD, SEND, DONE)
  - MSG_TERM = 8'h00
  - UART frame constants: start bit 0, stop bit 1, 8 data bits.
- Sub-module uart_tx_byte: baud counter plus bit counter and shift register.
  - Inputs: clk, rst, go, data[7:0]. Outputs: tx, frame_done (one-cycle pulse in the last stop-bit cycle).
  - Parameter CLKS_PER_BIT. Same reset convention as this block.
- Top-level FSM, pointer and counter live in msg_uart_reader.

## Test plan
Bench uses CLKS_PER_BIT=4 and ADDR_W=10.
- Reset: drive rst=0 mid-idle → tx=1, busy=0, done=0, ram_re=0, count=0.
- Two-character message: RAM[0x10]=0x48, RAM[0x11]=0x69, RAM[0x12]=0x00; start with base_addr=0x10.
  - ram_re reads addresses 0x10, 0x11, 0x12 in that order.
  - tx carries frames 0x48 then 0x69, LSB first, 40 cycles each.
  - done pulses once, count=2. Total 2·42 + 3 cycles from start to done.
- Empty message: RAM[0x20]=0x00 → done in cycle 3, tx never low, count=0.
- Length limit with MAX_LEN=4: RAM[0x00..0x07] all 0x41 → exactly 4 frames, done, no fifth ram_re.
- Start while busy: pulse start with base_addr=0x30 during the first frame → ignored; the address sequence is unchanged.
- Reset mid-frame: rst low during data bit 3 → tx=1 and busy=0 immediately. A new start re-reads from the new base_addr, and the first frame is complete and correct. Separately, with RAM[0x3FF]=0x41 and RAM[0x000]=0x00, start at base 0x3FF → ram_addr wraps to 0x000, count=1.
